// File: rtl/lock_arbiter.sv
// Hardware lock arbiter: serialises lock/unlock commands against a table of held
// locks (valid flops + owner RAM) and returns an ACK word for every lock command.
module lock_arbiter #(
  parameter int LOCK_ID_BITS = 8,
  parameter int ACC_ID_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic [ACC_ID_BITS-1:0] in_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [ACC_ID_BITS-1:0] out_dest,
  input  logic                   clear_all,
  output logic [LOCK_ID_BITS:0]  locks_held,
  output logic                   err
);

  localparam int ENTRIES = 2 ** LOCK_ID_BITS;

  localparam logic [7:0] CMD_LOCK   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK = 8'h06;
  localparam logic [7:0] ACK_OK     = 8'h01;
  localparam logic [7:0] ACK_REJECT = 8'h00;

  localparam logic [LOCK_ID_BITS:0] CNT_ONE = {{LOCK_ID_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOOKUP, DECIDE, ACK} state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0]      valid_q;
  logic [ACC_ID_BITS-1:0]  owner_mem [ENTRIES];
  logic [LOCK_ID_BITS:0]   cnt_q;
  logic                    err_q;

  logic [7:0]              cmd_q;
  logic [LOCK_ID_BITS-1:0] lid_q;
  logic [ACC_ID_BITS-1:0]  id_q;
  logic [ACC_ID_BITS-1:0]  owner_rd;
  logic                    held_rd;
  logic [7:0]              ack_q;

  logic accept, in_decide, is_lock, is_unlock, owned, grant, release_ok, bad;
  logic [7:0] ack_code;
  logic unused_bits;

  assign unused_bits = ^in_data[63:8+LOCK_ID_BITS];

  assign accept     = in_valid && in_ready;
  assign in_decide  = (state_q == DECIDE);
  assign is_lock    = (cmd_q == CMD_LOCK);
  assign is_unlock  = (cmd_q == CMD_UNLOCK);
  assign owned      = held_rd && (owner_rd == id_q);
  assign grant      = is_lock && !held_rd;
  assign release_ok = is_unlock && owned;
  assign bad        = !is_lock && !release_ok;
  // Re-locking by the current owner is idempotent and still acknowledged OK.
  assign ack_code   = (!held_rd || owned) ? ACK_OK : ACK_REJECT;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = DECIDE;
      DECIDE:  state_d = is_lock ? ACK : IDLE;
      ACK:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rstn && (state_q == IDLE) && !clear_all;
    out_valid = (state_q == ACK);
    out_data  = '0;
    out_dest  = '0;
    if (state_q == ACK) begin
      out_data = {{56{1'b0}}, ack_q};
      out_dest = id_q;
    end
  end

  // Table state and status; clear_all only acts in IDLE, so it never races DECIDE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= in_decide && bad;
      if ((state_q == IDLE) && clear_all) begin
        valid_q <= '0;
        cnt_q   <= '0;
      end else if (in_decide && grant) begin
        valid_q[lid_q] <= 1'b1;
        cnt_q          <= cnt_q + CNT_ONE;
      end else if (in_decide && release_ok) begin
        valid_q[lid_q] <= 1'b0;
        cnt_q          <= cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= in_data[7:0];
      lid_q <= in_data[8 +: LOCK_ID_BITS];
      id_q  <= in_id;
    end
    if (state_q == LOOKUP) begin
      owner_rd <= owner_mem[lid_q];
      held_rd  <= valid_q[lid_q];
    end
    if (in_decide) begin
      ack_q <= ack_code;
    end
  end

  always_ff @(posedge clk) begin
    if (in_decide && grant) begin
      owner_mem[lid_q] <= id_q;
    end
  end

  assign locks_held = cnt_q;
  assign err        = err_q;

endmodule

// File: doc/lock_arbiter.md
Name: lock_arbiter

Overview:
- Arbitrates the hardware lock resource (HWR_LOCK_ID 0x15) between accelerators.
- Consumes lock and unlock commands from the manager command stream. Keeps a table of held locks and their owners. Returns an ACK word to the requesting accelerator for every lock command.
- Sits between the HWR command interconnect and the accelerator ACK return stream. Processes one command at a time, so it serialises all lock traffic.

Parameters:
- LOCK_ID_BITS, 8: lock-id width; the table has 2**LOCK_ID_BITS entries.
- ACC_ID_BITS, 8: accelerator id width, used for owner and return-destination fields.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  command word valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_data  in  64  command: bits[7:0] cmd type; bits[15:8] lock id.
- in_id  in  ACC_ID_BITS  requesting accelerator id.
- out_valid  out  1  ACK valid.
- out_ready  in  1  ACK sink ready.
- out_data  out  64  ACK code.
- out_dest  out  ACC_ID_BITS  ACK destination, equal to the requester id.
- clear_all  in  1  synchronous pulse that releases every lock.
- locks_held  out  LOCK_ID_BITS+1  number of locks currently held.
- err  out  1  one-cycle pulse on an illegal unlock or an unknown command.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; all table valid bits=0; locks_held=0.
  - in_ready=0 during reset; out_valid=0; out_data=0; out_dest=0; err=0.
- Table storage:
  - valid bits in flops (2**LOCK_ID_BITS bits).
  - owner ids in RAM with a 1-cycle registered read; the owner RAM needs no reset.
- FSM states: IDLE, LOOKUP, DECIDE, ACK.
- IDLE:
  - in_ready=1 unless clear_all=1.
  - If clear_all=1: all valid bits cleared in one cycle, locks_held=0, no command accepted that cycle. clear_all has priority over in_valid.
  - Else on in_valid: latch cmd, lock id, in_id; go to LOOKUP.
- LOOKUP: read owner[lock id] and valid[lock id]; go to DECIDE. in_ready=0.
- DECIDE, cmd 0x04 (lock):
  - If lock is free: valid=1, owner=id, locks_held+1, ack=ACK_OK 0x01.
  - If already held by the same id: ack=ACK_OK, no count change (re-lock is idempotent).
  - If held by another id: ack=ACK_REJECT 0x00, table unchanged.
  - Go to ACK.
- DECIDE, cmd 0x06 (unlock):
  - If valid and owner==id: valid=0, locks_held-1, no ACK, go to IDLE.
  - Else: err pulse, table unchanged, go to IDLE.
- DECIDE, any other cmd: err pulse; command dropped; go to IDLE.
- ACK:
  - out_valid=1; out_data = ack zero-extended to 64 bits; out_dest = latched id.
  - Signals are held stable until out_ready. On out_valid && out_ready go to IDLE; out_valid deasserts next cycle.
- Latency and throughput:
  - Command accepted at edge N; out_valid is first high in the cycle after edge N+2 (3-cycle latency) when out_ready is held high.
  - Peak rate: one lock command per 4 cycles; one unlock per 3 cycles.
- Ordering: a table update made in DECIDE is visible to the next command, because only one command is in flight. No read-after-write hazard is possible.
- locks_held never wraps: it is bounded by 0..2**LOCK_ID_BITS by construction. The maximum is 256 with an all-locks-held table.
- clear_all is ignored outside IDLE. A command in flight completes against the pre-clear table. The next clear_all pulse in IDLE applies.
- Reset during ACK drops the pending ACK; the requester must retry.
- out_valid back-pressure has no timeout. in_ready stays 0 while in ACK.

Test Plan:
- Reset, then lock id=0x05 from acc 3 → out_valid after 3 cycles, out_data=0x01, out_dest=3, locks_held=1.
- With 0x05 held by acc 3: acc 7 locks 0x05 → out_data=0x00, out_dest=7, locks_held=1. Acc 3 locks 0x05 again → 0x01, locks_held=1.
- Acc 7 unlocks 0x05 (not owner) → err pulse, no ACK, 0x05 still held. Acc 3 unlocks → locks_held=0. Acc 7 then locks 0x05 → 0x01.
- out_ready held 0 for 10 cycles during an ACK → out_valid, out_data, out_dest stable and in_ready=0 throughout. ACK completes on the first out_ready.
- Lock ids 0x00, 0xFF, 0x80 from three accs, then clear_all in IDLE → locks_held goes 3→0. A following lock on 0xFF from another acc → 0x01. clear_all asserted together with in_valid → command not accepted that cycle.
- Cmd type 0x09 → err pulse, no ACK, table unchanged. rstn asserted in the middle of the ACK state → out_valid=0 immediately, locks_held=0.
